// File: rtl/ripple_carry_adder_4b_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// The master drives A/B/C0/in_valid and receives the registered result.
// The slave is the adder itself.
interface ripple_carry_adder_4b_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C0;
    logic             in_valid;
    logic [WIDTH-1:0] Sum;
    logic             Carry;
    logic             Overflow;
    logic             out_valid;

    modport master (
        output A, B, C0, in_valid,
        input  Sum, Carry, Overflow, out_valid
    );

    modport slave (
        input  A, B, C0, in_valid,
        output Sum, Carry, Overflow, out_valid
    );
endinterface

// File: rtl/ripple_carry_adder_4b.sv
// Registered ripple-carry adder: {Carry,Sum} = A + B + C0, one cycle latency.
// The sum is formed by an explicit chain of 1-bit full adders, carry rippling
// from bit 0 upward. Overflow flags signed overflow of the two's-complement add.
module ripple_carry_adder_4b #(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ripple_carry_adder_4b_if.slave bus
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    logic             ovf;

    // Full-adder chain; kept in one block so the carry vector is a single
    // ordered evaluation rather than a web of per-bit assigns.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = bus.C0;
        for (int i = 0; i < WIDTH; i++) begin
            s[i]   = bus.A[i] ^ bus.B[i] ^ c[i];
            c[i+1] = (bus.A[i] & bus.B[i]) | (bus.A[i] & c[i]) | (bus.B[i] & c[i]);
        end
        ovf = c[WIDTH] ^ c[WIDTH-1];
    end

    // Result register: capture on in_valid, otherwise hold the result and drop the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.Sum       <= '0;
            bus.Carry     <= 1'b0;
            bus.Overflow  <= 1'b0;
            bus.out_valid <= 1'b0;
        end else if (bus.in_valid) begin
            bus.Sum       <= s;
            bus.Carry     <= c[WIDTH];
            bus.Overflow  <= ovf;
            bus.out_valid <= 1'b1;
        end else begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ripple_carry_adder_4b.sv
// Bench for the registered 4-bit ripple-carry adder: arithmetic reference
// model checked every negedge, plus directed vectors with literal results.
module tb_ripple_carry_adder_4b;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    ripple_carry_adder_4b_if #(.WIDTH(4)) bus ();

    ripple_carry_adder_4b #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: what the registered outputs must hold.
    int m_sum   = 0;
    int m_carry = 0;
    int m_ovf   = 0;
    int m_valid = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: plain integer add for the result, signed range test for overflow.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sum   = 0;
            m_carry = 0;
            m_ovf   = 0;
            m_valid = 0;
        end else if (bus.in_valid) begin
            int a, b, c0, tot, sa, sb, st;
            a   = int'(bus.A);
            b   = int'(bus.B);
            c0  = int'(bus.C0);
            tot = a + b + c0;
            sa  = (a >= 8) ? a - 16 : a;
            sb  = (b >= 8) ? b - 16 : b;
            st  = sa + sb + c0;
            m_sum   = tot % 16;
            m_carry = tot / 16;
            m_ovf   = (st > 7 || st < -8) ? 1 : 0;
            m_valid = 1;
        end else begin
            m_valid = 0;
        end
    end

    // Compare process: every negedge once the bench has started driving.
    logic cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_sum",   int'(bus.Sum),       m_sum);
            check("model_carry", int'(bus.Carry),     m_carry);
            check("model_ovf",   int'(bus.Overflow),  m_ovf);
            check("model_valid", int'(bus.out_valid), m_valid);
        end
    end

    // Drive one input set (called just after a posedge), land just after the next posedge.
    task automatic step(input int a, input int b, input int c0, input int v);
        bus.A        = 4'(a);
        bus.B        = 4'(b);
        bus.C0       = 1'(c0);
        bus.in_valid = 1'(v);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_lit(input string name, input int s, input int c, input int o, input int v);
        check({name, "_sum"},   int'(bus.Sum),       s);
        check({name, "_carry"}, int'(bus.Carry),     c);
        check({name, "_ovf"},   int'(bus.Overflow),  o);
        check({name, "_valid"}, int'(bus.out_valid), v);
    endtask

    initial begin
        bus.A        = 4'(8'($urandom_range(0, 15)));
        bus.B        = 4'(8'($urandom_range(0, 15)));
        bus.C0       = 1'($urandom_range(0, 1));
        bus.in_valid = 1'b1;

        // Asynchronous reset before any clock edge, then held across an edge.
        #1 rst_n = 1'b0;
        #2;
        expect_lit("reset_async", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        expect_lit("reset_over_edge", 0, 0, 0, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        expect_lit("after_release_idle", 0, 0, 0, 0);
        cmp_en = 1'b1;

        step(4'b0000, 4'b0000, 0, 1); expect_lit("zero",       4'b0000, 0, 0, 1);
        step(4'b1000, 4'b0001, 0, 1); expect_lit("m8p1",       4'b1001, 0, 0, 1);
        step(4'b1000, 4'b0001, 1, 1); expect_lit("m8p1c",      4'b1010, 0, 0, 1);
        step(4'b1000, 4'b1111, 0, 1); expect_lit("m8m1",       4'b0111, 1, 1, 1);
        step(4'b1111, 4'b1111, 1, 1); expect_lit("max",        4'b1111, 1, 0, 1);
        step(4'b1111, 4'b0000, 1, 1); expect_lit("ripple",     4'b0000, 1, 0, 1);
        step(4'b0111, 4'b0001, 0, 1); expect_lit("pos_ovf",    4'b1000, 0, 1, 1);

        // Hold: capture 5+3, then drop in_valid and change operands.
        step(5, 3, 0, 1);             expect_lit("cap_5p3",    4'b1000, 0, 1, 1);
        step(4'b1111, 4'b1111, 1, 0); expect_lit("hold",       4'b1000, 0, 1, 0);
        step(2, 2, 0, 0);             expect_lit("hold2",      4'b1000, 0, 1, 0);

        // Mid-stream reset with a capture pending.
        bus.A = 4'd9; bus.B = 4'd9; bus.C0 = 1'b1; bus.in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        expect_lit("reset_mid", 0, 0, 0, 0);
        @(negedge clk);
        #2;
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_lit("reset_mid_idle", 0, 0, 0, 0);

        // Exhaustive back-to-back sweep, checked by the compare process.
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c0 = 0; c0 < 2; c0++)
                    step(a, b, c0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
